// File: rtl/byte_packer_n.sv
// byte_packer_n: packs WORDS beats of IN_W bits into one wide word. The wide
// word goes out over a valid/ready handshake. The accumulator and the output
// register form a double buffer, so collection can continue while the
// consumer stalls.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   clear        synchronous flush; it beats every other event in its cycle
//   in_data      beat data, sampled when in_valid=1
//   in_valid     single-cycle beat strobe
//   out_data     packed word; held stable while out_valid=1
//   out_valid    out_data holds an unconsumed word
//   out_ready    consumer accepts the word when out_valid & out_ready
//   beat_count   beats currently held in the accumulator (WORDS only when pending)
//   overflow     sticky; set when a beat is dropped
//   timeout_drop one-cycle pulse when a stale partial word is discarded
module byte_packer_n #(
  parameter int IN_W        = 8,
  parameter int WORDS       = 8,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic [IN_W*WORDS-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WORDS+1)-1:0]   beat_count,
  output logic                         overflow,
  output logic                         timeout_drop
);

  localparam int DW = IN_W * WORDS;
  localparam int CW = $clog2(WORDS + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(WORDS);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PENDING} state_t;

  state_t          r_state, w_state;
  logic [DW-1:0]   r_acc, w_acc;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [TW-1:0]   r_tcnt, w_tcnt;
  logic [DW-1:0]   r_out, w_out;
  logic            r_ov, w_ov;
  logic            r_ovf, w_ovf;
  logic            r_tdrop, w_tdrop;
  logic            w_free;
  logic [DW-1:0]   w_ins;
  logic [DW-1:0]   w_ins0;

  function automatic logic [DW-1:0] insert(input logic [DW-1:0] acc,
                                           input logic [IN_W-1:0] d);
    if (MSB_FIRST != 0) insert = {acc[DW-IN_W-1:0], d};
    else                insert = {d, acc[DW-1:IN_W]};
  endfunction

  always_comb begin
    w_free  = ~r_ov | out_ready;
    w_ins   = insert(r_acc, in_data);
    w_ins0  = insert('0, in_data);
    w_state = r_state;
    w_acc   = r_acc;
    w_cnt   = r_cnt;
    w_tcnt  = r_tcnt;
    w_out   = r_out;
    w_ov    = r_ov & ~out_ready;
    w_ovf   = r_ovf;
    w_tdrop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_acc   = w_ins;
          w_cnt   = CW'(1);
          w_tcnt  = '0;
          w_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          w_tcnt = '0;
          if (r_cnt == C_LAST) begin
            if (w_free) begin
              w_out   = w_ins;
              w_ov    = 1'b1;
              w_acc   = '0;
              w_cnt   = '0;
              w_state = S_IDLE;
            end else begin
              w_acc   = w_ins;
              w_cnt   = C_FULL;
              w_state = S_PENDING;
            end
          end else begin
            w_acc = w_ins;
            w_cnt = r_cnt + CW'(1);
          end
        end else if (TIMEOUT_CYC > 0) begin
          // A beat in the expiry cycle takes the branch above, so it wins.
          if (r_tcnt == T_LAST) begin
            w_acc   = '0;
            w_cnt   = '0;
            w_tcnt  = '0;
            w_tdrop = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_tcnt = r_tcnt + TW'(1);
          end
        end
      end
      S_PENDING: begin
        if (w_free) begin
          w_out  = r_acc;
          w_ov   = 1'b1;
          w_tcnt = '0;
          // A beat in the transfer cycle starts the next word.
          if (in_valid) begin
            w_acc   = w_ins0;
            w_cnt   = CW'(1);
            w_state = S_COLLECT;
          end else begin
            w_acc   = '0;
            w_cnt   = '0;
            w_state = S_IDLE;
          end
        end else if (in_valid) begin
          w_ovf = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_out   <= '0;
      r_ov    <= 1'b0;
      r_ovf   <= 1'b0;
      r_tdrop <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_out   <= '0;
      r_ov    <= 1'b0;
      r_ovf   <= 1'b0;
      r_tdrop <= 1'b0;
    end else begin
      r_state <= w_state;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt;
      r_tcnt  <= w_tcnt;
      r_out   <= w_out;
      r_ov    <= w_ov;
      r_ovf   <= w_ovf;
      r_tdrop <= w_tdrop;
    end
  end

  assign out_data     = r_out;
  assign out_valid    = r_ov;
  assign beat_count   = r_cnt;
  assign overflow     = r_ovf;
  assign timeout_drop = r_tdrop;

endmodule

// File: tb/tb_byte_packer_n.sv
// Testbench for byte_packer_n. Two instances share the stimulus:
//   A: MSB_FIRST=1 with a 20-cycle timeout
//   B: MSB_FIRST=0 with no timeout
// Each instance is compared against a beat-list reference model every cycle.
module tb_byte_packer_n;

  localparam int IN_W  = 8;
  localparam int WORDS = 8;
  localparam int DW    = IN_W * WORDS;
  localparam int TO_A  = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic [DW-1:0] a_data, b_data;
  logic          a_valid, b_valid;
  logic [3:0]    a_cnt, b_cnt;
  logic          a_ovf, b_ovf;
  logic          a_td, b_td;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  byte_packer_n #(.IN_W(IN_W), .WORDS(WORDS), .MSB_FIRST(1), .TIMEOUT_CYC(TO_A)) u_a (
    .clock(clock), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .beat_count(a_cnt),
    .overflow(a_ovf), .timeout_drop(a_td));

  byte_packer_n #(.IN_W(IN_W), .WORDS(WORDS), .MSB_FIRST(0), .TIMEOUT_CYC(0)) u_b (
    .clock(clock), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .beat_count(b_cnt),
    .overflow(b_ovf), .timeout_drop(b_td));

  // Reference model: list of beats collected so far, plus the output slot.
  logic [7:0]    m_beats [2][WORDS];
  int            m_n    [2];
  int            m_idle [2];
  bit            m_ov   [2];
  logic [DW-1:0] m_out  [2];
  bit            m_ovf  [2];
  bit            m_td   [2];

  function automatic logic [DW-1:0] pack(input int k);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k == 0) r = r | (DW'(m_beats[k][i]) << (IN_W * (WORDS - 1 - i)));
      else        r = r | (DW'(m_beats[k][i]) << (IN_W * i));
    end
    return r;
  endfunction

  task automatic m_reset(input int k);
    m_n[k] = 0; m_idle[k] = 0; m_ov[k] = 0; m_out[k] = '0; m_ovf[k] = 0; m_td[k] = 0;
  endtask

  task automatic m_step(input int k);
    bit free;
    int to;
    to = (k == 0) ? TO_A : 0;
    if (clear) begin
      m_reset(k);
      return;
    end
    m_td[k] = 0;
    free = !m_ov[k] || out_ready;
    if (m_n[k] == WORDS) begin
      if (free) begin
        m_out[k] = pack(k); m_ov[k] = 1; m_n[k] = 0; m_idle[k] = 0;
        if (in_valid) begin m_beats[k][0] = in_data; m_n[k] = 1; end
      end else if (in_valid) begin
        m_ovf[k] = 1;
      end
    end else begin
      if (m_ov[k] && out_ready) m_ov[k] = 0;
      if (in_valid) begin
        m_beats[k][m_n[k]] = in_data;
        m_n[k]++;
        m_idle[k] = 0;
        if (m_n[k] == WORDS && free) begin
          m_out[k] = pack(k); m_ov[k] = 1; m_n[k] = 0;
        end
      end else if (m_n[k] > 0 && to > 0) begin
        m_idle[k]++;
        if (m_idle[k] == to) begin m_n[k] = 0; m_idle[k] = 0; m_td[k] = 1; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_data",  a_data,         m_out[0]);
    chk("a_valid", DW'(a_valid),   DW'(m_ov[0]));
    chk("a_cnt",   DW'(a_cnt),     DW'(m_n[0]));
    chk("a_ovf",   DW'(a_ovf),     DW'(m_ovf[0]));
    chk("a_td",    DW'(a_td),      DW'(m_td[0]));
    chk("b_data",  b_data,         m_out[1]);
    chk("b_valid", DW'(b_valid),   DW'(m_ov[1]));
    chk("b_cnt",   DW'(b_cnt),     DW'(m_n[1]));
    chk("b_ovf",   DW'(b_ovf),     DW'(m_ovf[1]));
    chk("b_td",    DW'(b_td),      DW'(m_td[1]));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr = 1'b0);
    in_valid = v; in_data = d; out_ready = rdy; clear = clr;
    @(posedge clock);
    m_step(0); m_step(1);
    #1;
    check_all();
    in_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    m_reset(0); m_reset(1);
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock) reset = 1'b1;

    // Beats 01..08 with gaps: A packs MSB-first, B packs LSB-first
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b1);
      if (i == 8) begin
        chk("t1_a_word",  a_data, 64'h0102030405060708);
        chk("t2_b_word",  b_data, 64'h0807060504030201);
        chk("t1_a_valid", DW'(a_valid), DW'(1));
      end else begin
        step(1'b0, 8'h00, 1'b1);
      end
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t1_valid_drop", DW'(a_valid), DW'(0));

    // Stalled consumer: 16 beats, then one more beat overflows
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("t3_pending_cnt", DW'(a_cnt), DW'(8));
    chk("t3_no_ovf",      DW'(a_ovf), DW'(0));
    chk("t3_first_held",  a_data, 64'h1011121314151617);
    step(1'b1, 8'h20, 1'b0);
    chk("t3_ovf_set",     DW'(a_ovf), DW'(1));
    step(1'b0, 8'h00, 1'b1);
    chk("t3_second_word", a_data, 64'h18191A1B1C1D1E1F);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Timeout: 3 beats, 20 idle cycles
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
    for (int i = 0; i < TO_A; i++) step(1'b0, 8'h00, 1'b1);
    chk("t4_drop_pulse", DW'(a_td),  DW'(1));
    chk("t4_cnt_zero",   DW'(a_cnt), DW'(0));
    step(1'b0, 8'h00, 1'b1);
    chk("t4_pulse_once", DW'(a_td),  DW'(0));
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b1);
    chk("t4_word", a_data, 64'hA0A1A2A3A4A5A6A7);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    // Beat landing exactly on idle cycle 20 is accepted
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < TO_A - 1; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h43, 1'b1);
    chk("t4_edge_nodrop", DW'(a_td),  DW'(0));
    chk("t4_edge_cnt",    DW'(a_cnt), DW'(4));
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Drain and completion in the same cycle
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b1);
    chk("t5_no_bubble", DW'(a_valid), DW'(1));
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
    #2 reset = 1'b0;
    #1;
    m_reset(0); m_reset(1);
    check_all();
    @(negedge clock) reset = 1'b1;
    // Clear while pending
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    chk("t6_pending", DW'(a_cnt), DW'(8));
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("t6_clear_valid", DW'(a_valid), DW'(0));
    chk("t6_clear_data",  a_data, 64'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b1);
    chk("t6_clean_word", a_data, 64'hC0C1C2C3C4C5C6C7);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) == 0));
    end
    // Long idle stretches to exercise the timeout on random partials
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) step(1'b1, 8'($urandom), 1'b1);
      for (int i = 0; i < int'($urandom_range(15, 25)); i++) step(1'b0, 8'h00, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
